// File: rtl/trn_dqsw_seq_pkg.sv
// Shared definitions for the trn_* training blocks: sequencer state encoding,
// lane-index width helper and default timing constants.
package trn_dqsw_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_TRAIN  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_FINISH = 3'd4
  } trn_state_e;

  localparam logic [15:0] TRN_DEF_TIMEOUT = 16'hFFFF;
  localparam logic [7:0]  TRN_DEF_SETTLE  = 8'd16;

  // Width of a lane index; a single-lane build still gets a 1-bit index.
  function automatic int trn_lane_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/trn_dqsw_seq_dly_cnt.sv
// trn_dly_cnt: 16-bit loadable down-counter with a zero flag, shared by the
// timeout and settle phases of the lane sequencer.
module trn_dly_cnt (
  input  logic        sclk,
  input  logic        reset_b,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        dec,
  output logic        zero
);

  logic [15:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create simulation/synthesis races.
  always_ff @(posedge sclk or negedge reset_b) begin
    if (!reset_b) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != 16'd0)) begin
      cnt_q <= cnt_q - 16'd1;
    end
  end

  assign zero = (cnt_q == 16'd0);

endmodule

// File: rtl/trn_dqsw_seq.sv
// Lane sequencer for the DQSW/DQSW270 training engines: trains enabled lanes
// one at a time with a per-lane timeout and an inter-lane settle gap.
module trn_dqsw_seq
  import trn_dqsw_seq_pkg::*;
#(
  parameter int          NUM_LANES     = 4,
  parameter logic [15:0] TIMEOUT       = TRN_DEF_TIMEOUT,
  parameter logic [7:0]  SETTLE_CYCLES = TRN_DEF_SETTLE
) (
  input  logic                                sclk,
  input  logic                                reset_b,
  input  logic                                start,
  input  logic [NUM_LANES-1:0]                lane_en,
  input  logic [NUM_LANES-1:0]                skip_mask,
  input  logic [NUM_LANES-1:0]                lane_done,
  output logic [NUM_LANES-1:0]                lane_train,
  output logic [NUM_LANES-1:0]                lane_skip,
  output logic [trn_lane_w(NUM_LANES)-1:0]    cur_lane,
  output logic                                busy,
  output logic                                all_done,
  output logic                                timeout_err,
  output logic [NUM_LANES-1:0]                err_lanes
);

  localparam int LW = trn_lane_w(NUM_LANES);

  trn_state_e           state_q, state_d;
  logic [LW-1:0]        cur_q, cur_d;
  logic [NUM_LANES-1:0] en_q, skip_q, err_q;
  logic                 capture, err_set;
  logic                 tmr_load, tmr_dec, tmr_zero;
  logic [15:0]          tmr_val;
  logic                 last_lane;

  assign last_lane = (cur_q == LW'(NUM_LANES - 1));

  trn_dly_cnt u_dly_cnt (
    .sclk     (sclk),
    .reset_b  (reset_b),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // NOTE: every signal driven here gets a default first, so no path through the
  // case can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    capture  = 1'b0;
    err_set  = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          capture = 1'b1;
          cur_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (en_q[cur_q]) begin
          tmr_load = 1'b1;
          tmr_val  = TIMEOUT;
          state_d  = ST_TRAIN;
        end else if (last_lane) begin
          state_d = ST_FINISH;
        end else begin
          cur_d = cur_q + LW'(1);
        end
      end
      ST_TRAIN: begin
        // A done arriving on the timer's last cycle still counts as success.
        if (lane_done[cur_q]) begin
          tmr_load = 1'b1;
          tmr_val  = 16'(SETTLE_CYCLES);
          state_d  = ST_SETTLE;
        end else if (tmr_zero) begin
          err_set  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = 16'(SETTLE_CYCLES);
          state_d  = ST_SETTLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else if (last_lane) begin
          state_d = ST_FINISH;
        end else begin
          cur_d   = cur_q + LW'(1);
          state_d = ST_SCAN;
        end
      end
      ST_FINISH: begin
        state_d = ST_FINISH;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sclk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      en_q    <= '0;
      skip_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      if (capture) begin
        en_q   <= lane_en;
        skip_q <= skip_mask;
      end
      if (err_set) begin
        err_q[cur_q] <= 1'b1;
      end
    end
  end

  // Outputs decode from state and lane index only, never from inputs.
  always_comb begin
    lane_train = '0;
    if (state_q == ST_TRAIN) begin
      lane_train[cur_q] = 1'b1;
    end
  end

  assign lane_skip   = skip_q & lane_train;
  assign cur_lane    = cur_q;
  assign busy        = (state_q == ST_SCAN) || (state_q == ST_TRAIN) || (state_q == ST_SETTLE);
  assign all_done    = (state_q == ST_FINISH);
  assign err_lanes   = err_q;
  assign timeout_err = |err_q;

endmodule

// File: tb/tb_trn_dqsw_seq.sv
// Scoreboard bench for trn_dqsw_seq: a reference model predicts train episodes
// and completion per run; a monitor compares what the sequencer presents.
module tb_trn_dqsw_seq;

  localparam int NL    = 4;
  localparam int TMO   = 100;
  localparam int SET   = 5;
  localparam int NEVER = 1000000;

  logic          sclk = 1'b0;
  logic          reset_b = 1'b1;
  logic          start = 1'b0;
  logic [NL-1:0] lane_en = '0;
  logic [NL-1:0] skip_mask = '0;
  logic [NL-1:0] lane_done = '0;
  logic [NL-1:0] lane_train, lane_skip, err_lanes;
  logic [1:0]    cur_lane;
  logic          busy, all_done, timeout_err;

  trn_dqsw_seq #(
    .NUM_LANES     (NL),
    .TIMEOUT       (16'(TMO)),
    .SETTLE_CYCLES (8'(SET))
  ) dut (
    .sclk        (sclk),
    .reset_b     (reset_b),
    .start       (start),
    .lane_en     (lane_en),
    .skip_mask   (skip_mask),
    .lane_done   (lane_done),
    .lane_train  (lane_train),
    .lane_skip   (lane_skip),
    .cur_lane    (cur_lane),
    .busy        (busy),
    .all_done    (all_done),
    .timeout_err (timeout_err),
    .err_lanes   (err_lanes)
  );

  always #5 sclk = ~sclk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  typedef struct { int lane; int len; bit skip; } ep_t;
  typedef struct { int cyc; logic [NL-1:0] err; } fin_t;
  ep_t  ep_q[$];
  fin_t fin_q[$];

  int dly[NL];
  int cyc = 0;
  int t0  = 0;

  always @(posedge sclk) cyc++;

  // Engine model: done rises (and sticks) after train has been seen dly cycles.
  int tcnt[NL];
  always @(negedge sclk) begin
    for (int i = 0; i < NL; i++) begin
      if (!reset_b) begin
        tcnt[i]      = 0;
        lane_done[i] = 1'b0;
      end else if (lane_train[i] && !lane_done[i]) begin
        tcnt[i]++;
        if (tcnt[i] >= dly[i]) lane_done[i] = 1'b1;
      end
    end
  end

  // Monitor: measures each train episode and the arrival of all_done.
  bit   in_ep = 0, prev_done = 0, shape_ok = 1, skip_ok = 1, exp_skip = 0;
  int   ep_len = 0, ep_lane = 0;
  ep_t  e;
  fin_t f;
  always @(negedge sclk) begin
    if (!reset_b) begin
      in_ep     = 0;
      prev_done = 0;
    end else begin
      if (lane_train != '0) begin
        if (!in_ep) begin
          in_ep    = 1;
          ep_len   = 0;
          shape_ok = 1;
          skip_ok  = 1;
          for (int i = 0; i < NL; i++) if (lane_train[i]) ep_lane = i;
          exp_skip = (ep_q.size() != 0) ? ep_q[0].skip : 1'b0;
        end
        ep_len++;
        if ($countones(lane_train) != 1 || !lane_train[ep_lane] ||
            int'(cur_lane) != ep_lane || !busy || all_done) shape_ok = 0;
        if (lane_skip !== (exp_skip ? lane_train : '0)) skip_ok = 0;
      end else if (in_ep) begin
        in_ep = 0;
        if (ep_q.size() == 0) begin
          check("train_unexpected_lane", ep_lane, 32'hFF);
        end else begin
          e = ep_q.pop_front();
          check("train_lane", ep_lane, e.lane);
          check("train_len", ep_len, e.len);
          check("train_onehot_busy", shape_ok, 1);
          check("train_skip", skip_ok, 1);
        end
      end
      if (all_done && !prev_done) begin
        if (fin_q.size() == 0) begin
          check("finish_unexpected", 1, 0);
        end else begin
          f = fin_q.pop_front();
          check("finish_cycle", cyc - t0 + 1, f.cyc);
          check("finish_err_lanes", err_lanes, f.err);
          check("finish_timeout_err", timeout_err, |f.err);
          check("finish_busy_low", busy, 0);
          check("finish_train_low", lane_train, 0);
        end
      end
      prev_done = all_done;
    end
  end

  task automatic do_reset();
    @(posedge sclk);
    #2 reset_b = 1'b0;
    #1 check("reset_outputs_zero",
             {lane_train, lane_skip, cur_lane, busy, all_done, timeout_err, err_lanes}, 0);
    ep_q.delete();
    fin_q.delete();
    repeat (2) @(negedge sclk);
    reset_b = 1'b1;
    @(negedge sclk);
  endtask

  // Reference model: lanes in index order, train length capped at TMO+1.
  task automatic predict(input logic [NL-1:0] en, input logic [NL-1:0] sk);
    int t = 0;
    int len;
    logic [NL-1:0] err = '0;
    for (int i = 0; i < NL; i++) begin
      if (en[i]) begin
        len = (dly[i] > TMO + 1) ? TMO + 1 : dly[i];
        if (dly[i] > TMO + 1) err[i] = 1'b1;
        ep_q.push_back('{lane: i, len: len, skip: sk[i]});
        t += 1 + len + SET + 1;
      end else begin
        t += 1;
      end
    end
    fin_q.push_back('{cyc: t + 1, err: err});
  endtask

  task automatic issue_start(input logic [NL-1:0] en, input logic [NL-1:0] sk);
    @(negedge sclk);
    lane_en   = en;
    skip_mask = sk;
    start     = 1'b1;
    @(posedge sclk);
    #1 t0 = cyc;
    start = 1'b0;
    check("busy_cycle1", busy, 1);
    check("no_train_cycle1", lane_train, 0);
  endtask

  task automatic run(input logic [NL-1:0] en, input logic [NL-1:0] sk,
                     input int d0, input int d1, input int d2, input int d3,
                     input bit restart);
    int n = 0;
    do_reset();
    dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
    predict(en, sk);
    issue_start(en, sk);
    while (!all_done && n < 3000) begin
      @(negedge sclk);
      n++;
    end
    if (!all_done) check("finish_within_budget", 0, 1);
    repeat (2) @(negedge sclk);
    check("episodes_drained", ep_q.size(), 0);
    check("finish_drained", fin_q.size(), 0);
    if (restart) begin
      lane_en = '1;
      start   = 1'b1;
      repeat (3) @(negedge sclk);
      start = 1'b0;
      repeat (3) @(negedge sclk);
      check("finish_ignores_start_done", all_done, 1);
      check("finish_ignores_start_busy", busy, 0);
      check("finish_ignores_start_train", lane_train, 0);
    end
  endtask

  task automatic reset_mid_train();
    int n = 0;
    do_reset();
    for (int i = 0; i < NL; i++) dly[i] = 30;
    ep_q.push_back('{lane: 0, len: 30, skip: 1'b0});
    issue_start(4'b1111, 4'b0000);
    while (!lane_train[1] && n < 1000) begin
      @(negedge sclk);
      n++;
    end
    check("lane1_reached", lane_train[1], 1);
    repeat (5) @(negedge sclk);
    #2 reset_b = 1'b0;
    #1 check("async_reset_outputs_zero",
             {lane_train, lane_skip, cur_lane, busy, all_done, timeout_err, err_lanes}, 0);
    ep_q.delete();
    fin_q.delete();
    repeat (2) @(negedge sclk);
    reset_b = 1'b1;
    repeat (10) @(negedge sclk);
    check("idle_after_reset_busy", busy, 0);
    check("idle_after_reset_done", all_done, 0);
    check("idle_after_reset_train", lane_train, 0);
  endtask

  initial begin
    run(4'b1111, 4'b0000, 50, 50, 50, 50, 0);
    run(4'b1010, 4'b1000, 12, 7, 9, 23, 0);
    run(4'b1111, 4'b0000, 20, 20, NEVER, 20, 0);
    run(4'b0011, 4'b0001, TMO + 1, TMO + 2, 5, 5, 0);
    run(4'b1001, 4'b1001, 1, 3, 3, 1, 0);
    reset_mid_train();
    run(4'b0000, 4'b0110, 5, 5, 5, 5, 1);
    for (int r = 0; r < 10; r++) begin
      int d[NL];
      for (int i = 0; i < NL; i++)
        d[i] = ($urandom_range(0, 6) == 0) ? NEVER : int'($urandom_range(1, TMO + 3));
      run(NL'($urandom), NL'($urandom), d[0], d[1], d[2], d[3], 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
